psum_deskew_collector: RTL

//  Sits directly downstream of the systolic array and its conv controller. Takes skewed
//  per-column partial sums qualified by the controller's out_en[col-1:0] and re-aligns them

---
 rtl/psum_deskew_collector.sv | 130 +++++++++++++
 1 files changed

// File: rtl/psum_deskew_collector.sv
// Re-aligns diagonally skewed column psums into rows and queues them; row_valid 2 edges after the last column.
// Valid/ready output; a full FIFO without a same-cycle pop drops the row and sets sticky overflow.
module psum_deskew_collector #(
    parameter int col        = 32,
    parameter int psum_w     = 32,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clear,
    input  logic [col-1:0]        out_en,
    input  logic [col*psum_w-1:0] psum_in,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [col*psum_w-1:0] row_data,
    output logic [15:0]           row_count,
    output logic                  overflow,
    output logic                  misalign
);
    localparam int AW = $clog2(fifo_depth);
    localparam int RW = col * psum_w;

    logic [col-1:0][psum_w-1:0] w_dsk_dat;
    logic [col-1:0]             w_dsk_vld;

    // Column j waits col-1-j cycles so every column of a row lands together.
    for (genvar j = 0; j < col; j++) begin : g_col
        localparam int D = col - 1 - j;
        if (D == 0) begin : g_direct
            assign w_dsk_dat[j] = psum_in[j*psum_w +: psum_w];
            assign w_dsk_vld[j] = out_en[j];
        end else begin : g_dly
            logic [psum_w-1:0] r_dl_dat [D];
            logic [D-1:0]      r_dl_vld;

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int k = 0; k < D; k++) r_dl_dat[k] <= '0;
                    r_dl_vld <= '0;
                end else if (clear) begin
                    for (int k = 0; k < D; k++) r_dl_dat[k] <= '0;
                    r_dl_vld <= '0;
                end else begin
                    r_dl_dat[0] <= psum_in[j*psum_w +: psum_w];
                    r_dl_vld[0] <= out_en[j];
                    for (int k = 1; k < D; k++) begin
                        r_dl_dat[k] <= r_dl_dat[k-1];
                        r_dl_vld[k] <= r_dl_vld[k-1];
                    end
                end
            end

            assign w_dsk_dat[j] = r_dl_dat[D-1];
            assign w_dsk_vld[j] = r_dl_vld[D-1];
        end
    end

    logic [RW-1:0]  r_al_dat;
    logic [col-1:0] r_al_vld;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_al_dat <= '0;
            r_al_vld <= '0;
        end else if (clear) begin
            r_al_dat <= '0;
            r_al_vld <= '0;
        end else begin
            r_al_dat <= w_dsk_dat;
            r_al_vld <= w_dsk_vld;
        end
    end

    logic [RW-1:0] r_mem [fifo_depth];
    logic [RW-1:0] r_last;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [15:0]   r_row_count;
    logic          r_overflow;
    logic          r_misalign;

    logic w_empty, w_full, w_pop, w_push_req, w_push, w_partial;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = !w_empty && row_ready;
    assign w_push_req = &r_al_vld;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_partial  = (|r_al_vld) && !(&r_al_vld);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < fifo_depth; k++) r_mem[k] <= '0;
            r_last      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_row_count <= '0;
            r_overflow  <= 1'b0;
            r_misalign  <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < fifo_depth; k++) r_mem[k] <= '0;
            r_last      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_row_count <= '0;
            r_overflow  <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= r_al_dat;
                r_wr_ptr    <= r_wr_ptr + (AW+1)'(1);
                r_row_count <= r_row_count + 16'd1;
            end
            // Keep a copy of the departing head so row_data holds once the FIFO drains.
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (w_push_req && !w_push) r_overflow <= 1'b1;
            if (w_partial)             r_misalign <= 1'b1;
        end
    end

    assign row_valid = !w_empty;
    assign row_data  = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];
    assign row_count = r_row_count;
    assign overflow  = r_overflow;
    assign misalign  = r_misalign;
endmodule
